// File: rtl/contador_comparador_param_if.sv
// Bus between the control unit and the parametrised counter/comparator datapath.
// Control-side signals are outputs of the master; status/debug signals are outputs of the slave.
interface contador_comparador_param_if #(
    parameter int unsigned N = 4,
    parameter int unsigned V = 4
);
    logic         carrega;
    logic         conta;
    logic         desce;
    logic [N-1:0] dado;
    logic [N-1:0] chaves;
    logic         menor;
    logic         maior;
    logic         igual;
    logic         fim;
    logic [N-1:0] db_contagem;
    logic [V-1:0] db_voltas;

    modport master (
        output carrega, conta, desce, dado, chaves,
        input  menor, maior, igual, fim, db_contagem, db_voltas
    );

    modport slave (
        input  carrega, conta, desce, dado, chaves,
        output menor, maior, igual, fim, db_contagem, db_voltas
    );
endinterface

// File: rtl/contador_comparador_param.sv
// Modulo-M up/down counter with clamped load, magnitude comparator, end-of-count flag and
// saturating wrap counter. Define COMPARADOR_REGISTRADO_EN to register menor/maior/igual.
module contador_comparador_param #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 16,
    parameter int unsigned V = 4
) (
    input  logic                         clock,
    input  logic                         zera,
    contador_comparador_param_if.slave   bus
);
    localparam logic [N-1:0] CountMax = N'(M - 1);
    localparam logic [N:0]   Modulus  = (N + 1)'(M);
    localparam logic [N-1:0] CountOne = N'(1);
    localparam logic [V-1:0] VoltaOne = V'(1);

    logic [N-1:0] contagem_q, contagem_d;
    logic [V-1:0] voltas_q, voltas_d;
    logic         terminal;
    logic         wrap;
    logic         lt, gt, eq;

    always_comb begin
        terminal   = bus.desce ? (contagem_q == '0) : (contagem_q == CountMax);
        // zera is not folded in here: the register's reset branch already overrides it.
        wrap       = bus.conta & ~bus.carrega & terminal;
        contagem_d = contagem_q;
        voltas_d   = voltas_q;
        if (bus.carrega) begin
            contagem_d = ({1'b0, bus.dado} < Modulus) ? bus.dado : CountMax;
        end else if (bus.conta) begin
            if (terminal) begin
                contagem_d = bus.desce ? CountMax : '0;
            end else begin
                contagem_d = bus.desce ? (contagem_q - CountOne) : (contagem_q + CountOne);
            end
        end
        if (wrap && (voltas_q != '1)) begin
            voltas_d = voltas_q + VoltaOne;
        end
    end

    always_ff @(posedge clock) begin
        if (zera) begin
            contagem_q <= '0;
            voltas_q   <= '0;
        end else begin
            contagem_q <= contagem_d;
            voltas_q   <= voltas_d;
        end
    end

    always_comb begin
        lt = contagem_q < bus.chaves;
        gt = contagem_q > bus.chaves;
        eq = contagem_q == bus.chaves;
    end

`ifdef COMPARADOR_REGISTRADO_EN
    logic menor_q, maior_q, igual_q;

    always_ff @(posedge clock) begin
        if (zera) begin
            menor_q <= 1'b0;
            maior_q <= 1'b0;
            igual_q <= 1'b1;
        end else begin
            menor_q <= lt;
            maior_q <= gt;
            igual_q <= eq;
        end
    end

    assign bus.menor = menor_q;
    assign bus.maior = maior_q;
    assign bus.igual = igual_q;
`else
    assign bus.menor = lt;
    assign bus.maior = gt;
    assign bus.igual = eq;
`endif

    assign bus.fim         = bus.conta & terminal;
    assign bus.db_contagem = contagem_q;
    assign bus.db_voltas   = voltas_q;
endmodule

// File: tb/tb_contador_comparador_param.sv
// Self-checking bench for contador_comparador_param (N=4, M=10, V=2) against an arithmetic model.
module tb_contador_comparador_param;
    localparam int N = 4;
    localparam int M = 10;
    localparam int V = 2;
    localparam int VMAX = (1 << V) - 1;

    logic clock = 1'b0;
    logic zera  = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int       m_cnt = 0;
    int       m_volt = 0;
    logic [2:0] m_flags = 3'b001;  // {menor, maior, igual} as seen through the flag registers

    logic [9:0] got, exp;

    contador_comparador_param_if #(.N(N), .V(V)) bus ();

    contador_comparador_param #(.N(N), .M(M), .V(V)) dut (
        .clock (clock),
        .zera  (zera),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] exp_out();
        logic lt, gt, eq, f;
        lt = m_cnt < int'(bus.chaves);
        gt = m_cnt > int'(bus.chaves);
        eq = m_cnt == int'(bus.chaves);
`ifdef COMPARADOR_REGISTRADO_EN
        {lt, gt, eq} = m_flags;
`endif
        f = bus.conta && (bus.desce ? (m_cnt == 0) : (m_cnt == M - 1));
        return {lt, gt, eq, f, 4'(m_cnt), 2'(m_volt)};
    endfunction

    // Advance the model by one edge from the inputs currently applied, then take the edge.
    task automatic step();
        bit wrapped = 0;
        if (zera) m_flags = 3'b001;
        else m_flags = {m_cnt < int'(bus.chaves), m_cnt > int'(bus.chaves),
                        m_cnt == int'(bus.chaves)};
        if (zera) begin
            m_cnt = 0;
            m_volt = 0;
        end else if (bus.carrega) begin
            m_cnt = (int'(bus.dado) < M) ? int'(bus.dado) : M - 1;
        end else if (bus.conta) begin
            if (!bus.desce) begin
                wrapped = (m_cnt == M - 1);
                m_cnt = (m_cnt + 1) % M;
            end else begin
                wrapped = (m_cnt == 0);
                m_cnt = (m_cnt + M - 1) % M;
            end
            if (wrapped && m_volt < VMAX) m_volt++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        zera = 0;
        bus.carrega = 0;
        bus.conta = 0;
        bus.desce = 0;
        bus.dado = '0;
        bus.chaves = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        zera = 1;
        step();
        zera = 0;
        got = {bus.menor, bus.maior, bus.igual, bus.fim, bus.db_contagem, bus.db_voltas};
        checks++;
        if (got !== 10'b001_0_0000_00) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", got, 10'b001_0_0000_00);
        end
        exp = exp_out();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_model got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_count_up();
        bus.conta = 1;
        bus.desce = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            got = {bus.menor, bus.maior, bus.igual, bus.fim, bus.db_contagem, bus.db_voltas};
            exp = exp_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL count_up step=%0d got=%b exp=%b", i, got, exp);
            end
        end
        checks++;
        if (bus.db_contagem !== 4'd2 || bus.db_voltas !== 2'd1) begin
            failures++;
            $display("FAIL count_up_end got=%0d/%0d exp=2/1", bus.db_contagem, bus.db_voltas);
        end
        bus.conta = 0;
    endtask

    task automatic test_load();
        bus.carrega = 1;
        bus.dado = 4'd13;
        step();
        checks++;
        if (bus.db_contagem !== 4'd9) begin
            failures++;
            $display("FAIL load_clamp got=%0d exp=9", bus.db_contagem);
        end
        bus.dado = 4'd6;
        bus.conta = 1;
        step();
        got = {bus.menor, bus.maior, bus.igual, bus.fim, bus.db_contagem, bus.db_voltas};
        exp = exp_out();
        checks++;
        if (got !== exp || bus.db_contagem !== 4'd6) begin
            failures++;
            $display("FAIL load_priority got=%b exp=%b", got, exp);
        end
        bus.carrega = 0;
        bus.conta = 0;
    endtask

    task automatic test_count_down();
        logic [V-1:0] v0;
        bus.carrega = 1;
        bus.dado = 4'd1;
        step();
        bus.carrega = 0;
        v0 = bus.db_voltas;
        bus.conta = 1;
        bus.desce = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = {bus.menor, bus.maior, bus.igual, bus.fim, bus.db_contagem, bus.db_voltas};
            exp = exp_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL count_down step=%0d got=%b exp=%b", i, got, exp);
            end
        end
        checks++;
        if (bus.db_contagem !== 4'd9 || bus.db_voltas !== v0 + 2'd1) begin
            failures++;
            $display("FAIL count_down_end got=%0d/%0d exp=9/%0d", bus.db_contagem,
                     bus.db_voltas, v0 + 2'd1);
        end
        bus.conta = 0;
        bus.desce = 0;
    endtask

    task automatic test_saturate();
        zera = 1;
        step();
        zera = 0;
        bus.conta = 1;
        repeat (5 * M) step();
        checks++;
        if (bus.db_voltas !== 2'd3 || m_volt != VMAX) begin
            failures++;
            $display("FAIL voltas_saturate got=%0d exp=3", bus.db_voltas);
        end
        zera = 1;
        bus.carrega = 1;
        bus.dado = 4'd5;
        step();
        zera = 0;
        bus.carrega = 0;
        checks++;
        if (bus.db_contagem !== 4'd0 || bus.db_voltas !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_count got=%0d/%0d exp=0/0", bus.db_contagem, bus.db_voltas);
        end
        bus.conta = 0;
    endtask

    task automatic test_compare_sweep();
        logic [2:0] want;
        bus.chaves = 4'd6;
        for (int v = 0; v < M; v++) begin
            bus.carrega = 1;
            bus.dado = 4'(v);
            step();
            bus.carrega = 0;
            step();
            want = (v < 6) ? 3'b100 : (v > 6) ? 3'b010 : 3'b001;
            got = {bus.menor, bus.maior, bus.igual, bus.fim, bus.db_contagem, bus.db_voltas};
            exp = exp_out();
            checks++;
            if (got[9:7] !== want || got !== exp) begin
                failures++;
                $display("FAIL compare v=%0d got=%b exp=%b flags_exp=%b", v, got, exp, want);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            zera = ($urandom_range(0, 19) == 0);
            bus.carrega = ($urandom_range(0, 7) == 0);
            bus.conta = ($urandom_range(0, 3) != 0);
            bus.desce = 1'($urandom);
            bus.dado = 4'($urandom);
            bus.chaves = 4'($urandom);
            step();
            zera = 0;
            got = {bus.menor, bus.maior, bus.igual, bus.fim, bus.db_contagem, bus.db_voltas};
            exp = exp_out();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_count_up();
        test_load();
        test_count_down();
        test_saturate();
        test_compare_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
